// File: rtl/prog_launcher_pkg.sv
// Shared definitions for the program launcher.
//   state_t  : launcher FSM states
//   PIW      : width of the program index output
//   last_idx : index of the final program in a sequence of n programs
package prog_launcher_pkg;

  localparam int PIW = 4;

  typedef enum logic [2:0] {
    IDLE,
    CORE_RST,
    START_HI,
    RUN,
    RECORD,
    FINISHED
  } state_t;

  function automatic logic [PIW-1:0] last_idx(input int n);
    return PIW'(n - 1);
  endfunction

endpackage

// File: rtl/prog_launcher_run.sv
// run_timer: run-length counter for one program run.
//   clk     : clock
//   reset   : synchronous, active-high; clears the count
//   clear   : synchronous clear, wins over enable
//   enable  : count up by one this cycle
//   count   : current run length in cycles
//   hit     : count has reached TIMEOUT
// TIMEOUT is below the all-ones value, so the count never wraps while the
// owner stops counting at the hit.
module run_timer #(
  parameter int             CW      = 16,
  parameter logic [CW-1:0]  TIMEOUT = 16'hFFF0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          hit
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign hit = (count == TIMEOUT);

endmodule

// File: rtl/prog_launcher.sv
// prog_launcher: drives the core's reset/start handshake for a sequence of
// NUM_PROGS programs and reports the run length of each.
//   clk            : clock, all state changes on posedge
//   reset          : synchronous, active-high
//   go             : begin a sequence (sampled in IDLE and FINISHED only)
//   done_in        : core done/halt level
//   core_reset     : reset to the core, one cycle at the start of a sequence
//   start          : start request to the core, START_CYCLES cycles per launch
//   prog_idx       : index of the program currently being run
//   busy           : high outside IDLE and FINISHED
//   result_valid   : one-cycle pulse when a result is recorded
//   result_cycles  : run length of the program just completed
//   result_timeout : the recorded run was abandoned at TIMEOUT
//   all_done       : high in FINISHED
// All outputs are registered and take the value of the state being entered.
module prog_launcher
  import prog_launcher_pkg::*;
#(
  parameter int            NUM_PROGS    = 3,
  parameter int            START_CYCLES = 2,
  parameter int            CW           = 16,
  parameter logic [CW-1:0] TIMEOUT      = 16'hFFF0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go,
  input  logic           done_in,
  output logic           core_reset,
  output logic           start,
  output logic [PIW-1:0] prog_idx,
  output logic           busy,
  output logic           result_valid,
  output logic [CW-1:0]  result_cycles,
  output logic           result_timeout,
  output logic           all_done
);

  localparam int            HW        = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_CYCLES - 1);
  localparam logic [PIW-1:0] PROG_LAST = last_idx(NUM_PROGS);

  state_t        state;
  logic [HW-1:0] hold;
  logic          done_armed;
  logic [CW-1:0] count;
  logic          hit;

  // The counter sits at zero in every state but RUN, so the first RUN cycle
  // always sees count == 0 and the value at exit is the run length.
  run_timer #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != RUN),
    .enable (state == RUN),
    .count  (count),
    .hit    (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      core_reset     <= 1'b1;
      start          <= 1'b0;
      prog_idx       <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      all_done       <= 1'b0;
      hold           <= '0;
      done_armed     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      core_reset   <= 1'b0;

      case (state)
        IDLE: begin
          if (go) begin
            state      <= CORE_RST;
            core_reset <= 1'b1;
            busy       <= 1'b1;
            prog_idx   <= '0;
          end
        end

        CORE_RST: begin
          state    <= START_HI;
          start    <= 1'b1;
          hold     <= '0;
          prog_idx <= '0;
        end

        START_HI: begin
          // A done left over from the previous program must be seen low
          // before it can complete this run.
          if (!done_in) begin
            done_armed <= 1'b1;
          end
          if (hold == HOLD_LAST) begin
            state <= RUN;
            start <= 1'b0;
          end else begin
            hold <= hold + HW'(1);
          end
        end

        RUN: begin
          if (!done_in) begin
            done_armed <= 1'b1;
          end
          // Done is checked first so a done arriving on the timeout cycle
          // is reported as a normal completion.
          if (done_armed && done_in) begin
            state          <= RECORD;
            result_valid   <= 1'b1;
            result_cycles  <= count;
            result_timeout <= 1'b0;
          end else if (hit) begin
            state          <= RECORD;
            result_valid   <= 1'b1;
            result_cycles  <= count;
            result_timeout <= 1'b1;
          end
        end

        RECORD: begin
          done_armed <= 1'b0;
          if (prog_idx == PROG_LAST) begin
            state    <= FINISHED;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end else begin
            state    <= START_HI;
            prog_idx <= prog_idx + PIW'(1);
            start    <= 1'b1;
            hold     <= '0;
          end
        end

        FINISHED: begin
          if (go) begin
            state      <= CORE_RST;
            core_reset <= 1'b1;
            busy       <= 1'b1;
            all_done   <= 1'b0;
            prog_idx   <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_launcher.sv
module tb_prog_launcher;

  localparam int NP     = 3;
  localparam int SC     = 2;
  localparam int CW     = 16;
  localparam int TO     = 32;
  localparam int BUDGET = NP * (TO + 8) + 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic          done_in;
  logic          core_reset;
  logic          start;
  logic [3:0]    prog_idx;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] result_cycles;
  logic          result_timeout;
  logic          all_done;

  int checks   = 0;
  int failures = 0;

  prog_launcher #(
    .NUM_PROGS    (NP),
    .START_CYCLES (SC),
    .CW           (CW),
    .TIMEOUT      (16'd32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .go             (go),
    .done_in        (done_in),
    .core_reset     (core_reset),
    .start          (start),
    .prog_idx       (prog_idx),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_cycles  (result_cycles),
    .result_timeout (result_timeout),
    .all_done       (all_done)
  );

  always #5 clk = ~clk;

  // Core behaviour per program: either done rises p_delay cycles after start
  // falls (p_delay < 0: never), or, when p_stale >= 0, done is high from the
  // start pulse onward except for one low cycle at RUN cycle p_stale.
  int p_delay [NP];
  int p_stale [NP];

  function automatic logic wave(input int p, input int k);
    if (p_stale[p] >= 0) return (k != p_stale[p]);
    return (p_delay[p] >= 0 && k >= p_delay[p]);
  endfunction

  // Expected outcome straight from the handshake rules.
  function automatic void model(input int d, input int s, output int cyc, output bit to);
    if (s >= 0) begin
      if (s + 1 <= TO) begin cyc = s + 1; to = 1'b0; end
      else             begin cyc = TO;    to = 1'b1; end
    end else if (d >= 0 && d <= TO) begin
      cyc = d; to = 1'b0;
    end else begin
      cyc = TO; to = 1'b1;
    end
  endfunction

  // Core model driving done_in.
  initial begin : core_model
    int  k;
    bit  in_run;
    bit  prev_start;
    done_in = 1'b0; k = 0; in_run = 1'b0; prev_start = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!busy) begin
        in_run  = 1'b0;
        done_in = 1'b0;
      end else if (start) begin
        in_run  = 1'b0;
        done_in = (p_stale[int'(prog_idx)] >= 0);
      end else if (prev_start) begin
        in_run  = 1'b1;
        k       = 0;
        done_in = wave(int'(prog_idx), 0);
      end else if (in_run && !result_valid) begin
        k       = k + 1;
        done_in = wave(int'(prog_idx), k);
      end else begin
        in_run = 1'b0;
      end
      prev_start = start;
    end
  end

  typedef struct {
    int idx;
    int cyc;
    bit to;
  } res_t;

  res_t rq[$];
  int   rst_cnt;
  int   st_cnt [NP];

  always @(negedge clk) begin
    if (!reset) begin
      if (result_valid) rq.push_back('{int'(prog_idx), int'(result_cycles), result_timeout});
      if (core_reset) rst_cnt = rst_cnt + 1;
      if (start && int'(prog_idx) < NP) st_cnt[int'(prog_idx)] = st_cnt[int'(prog_idx)] + 1;
    end
  end

  task automatic clear_obs();
    rq.delete();
    rst_cnt = 0;
    for (int i = 0; i < NP; i++) st_cnt[i] = 0;
  endtask

  task automatic run_seq(input string name);
    int n;
    clear_obs();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0;
    while (!all_done && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (all_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_finish: all_done=%0b after %0d cycles, required 1", name, all_done, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({core_reset, start, prog_idx, busy, result_valid, result_cycles, result_timeout, all_done}
        !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: cr=%0b st=%0b idx=%0d busy=%0b rv=%0b rc=%0d rt=%0b ad=%0b, required cr=1 rest 0",
               core_reset, start, prog_idx, busy, result_valid, result_cycles, result_timeout, all_done);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (core_reset !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: core_reset=%0b busy=%0b, required 0 0", core_reset, busy);
    end
  endtask

  task automatic test_normal();
    int ec; bit et;
    p_delay = '{10, 25, 7};
    p_stale = '{-1, -1, -1};
    run_seq("normal");
    checks++;
    if (rq.size() != NP) begin
      failures++;
      $display("FAIL normal_count: results=%0d, required %0d", rq.size(), NP);
    end
    for (int i = 0; i < NP && i < rq.size(); i++) begin
      model(p_delay[i], p_stale[i], ec, et);
      checks += 3;
      if (rq[i].idx != i) begin failures++; $display("FAIL normal_idx%0d: got %0d, required %0d", i, rq[i].idx, i); end
      if (rq[i].cyc != ec) begin failures++; $display("FAIL normal_cycles%0d: got %0d, required %0d", i, rq[i].cyc, ec); end
      if (rq[i].to != et) begin failures++; $display("FAIL normal_timeout%0d: got %0b, required %0b", i, rq[i].to, et); end
    end
    checks += 2;
    if (rst_cnt != 1) begin failures++; $display("FAIL normal_core_reset: high %0d cycles, required 1", rst_cnt); end
    if (result_cycles !== 16'd7) begin failures++; $display("FAIL normal_hold: result_cycles=%0d, required 7", result_cycles); end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (st_cnt[i] != SC) begin failures++; $display("FAIL normal_start%0d: high %0d cycles, required %0d", i, st_cnt[i], SC); end
    end
  endtask

  // Stale done, plain timeout, and done on the timeout cycle in one sequence.
  task automatic test_corners();
    int ec; bit et;
    p_delay = '{-1, -1, TO};
    p_stale = '{4, -1, -1};
    run_seq("corners");
    checks++;
    if (rq.size() != NP) begin
      failures++;
      $display("FAIL corners_count: results=%0d, required %0d", rq.size(), NP);
    end
    for (int i = 0; i < NP && i < rq.size(); i++) begin
      model(p_delay[i], p_stale[i], ec, et);
      checks += 3;
      if (rq[i].idx != i) begin failures++; $display("FAIL corners_idx%0d: got %0d, required %0d", i, rq[i].idx, i); end
      if (rq[i].cyc != ec) begin failures++; $display("FAIL corners_cycles%0d: got %0d, required %0d", i, rq[i].cyc, ec); end
      if (rq[i].to != et) begin failures++; $display("FAIL corners_timeout%0d: got %0b, required %0b", i, rq[i].to, et); end
    end
  endtask

  task automatic test_relaunch();
    int n;
    clear_obs();
    p_delay = '{3, 4, 5};
    p_stale = '{-1, -1, -1};
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    checks++;
    if ({core_reset, all_done, prog_idx, busy, start} !== {1'b1, 1'b0, 4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL relaunch_entry: cr=%0b ad=%0b idx=%0d busy=%0b st=%0b, required 1 0 0 1 0",
               core_reset, all_done, prog_idx, busy, start);
    end
    @(posedge clk); #1;
    checks++;
    if (core_reset !== 1'b0 || start !== 1'b1) begin
      failures++;
      $display("FAIL relaunch_start: core_reset=%0b start=%0b, required 0 1", core_reset, start);
    end
    n = 0;
    while (!all_done && n < BUDGET) begin @(posedge clk); #1; n++; end
    checks += 3;
    if (all_done !== 1'b1) begin failures++; $display("FAIL relaunch_finish: all_done=%0b, required 1", all_done); end
    if (st_cnt[0] != SC) begin failures++; $display("FAIL relaunch_start_len: %0d cycles, required %0d", st_cnt[0], SC); end
    if (rq.size() != NP) begin failures++; $display("FAIL relaunch_count: results=%0d, required %0d", rq.size(), NP); end
  endtask

  task automatic test_midreset();
    int n;
    clear_obs();
    p_delay = '{6, -1, 6};
    p_stale = '{-1, -1, -1};
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0;
    while (!(prog_idx == 4'd1 && busy && !start) && n < BUDGET) begin @(posedge clk); #1; n++; end
    checks++;
    if (!(prog_idx == 4'd1 && busy && !start)) begin
      failures++;
      $display("FAIL midreset_reach_run: idx=%0d busy=%0b start=%0b, required 1 1 0", prog_idx, busy, start);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if ({busy, prog_idx, start, core_reset, result_valid, all_done} !== {1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_values: busy=%0b idx=%0d st=%0b cr=%0b rv=%0b ad=%0b, required 0 0 0 1 0 0",
               busy, prog_idx, start, core_reset, result_valid, all_done);
    end
    if (rq.size() != 1) begin failures++; $display("FAIL midreset_results: got %0d, required 1", rq.size()); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (core_reset !== 1'b0) begin failures++; $display("FAIL midreset_release: core_reset=%0b, required 0", core_reset); end
    p_delay = '{2, 3, 4};
    run_seq("midreset_restart");
    checks += 2;
    if (rq.size() != NP) begin failures++; $display("FAIL midreset_restart_count: %0d, required %0d", rq.size(), NP); end
    if (rq.size() > 0 && (rq[0].idx != 0 || rq[0].cyc != 2)) begin
      failures++;
      $display("FAIL midreset_restart_first: idx=%0d cyc=%0d, required 0 2", rq[0].idx, rq[0].cyc);
    end
  endtask

  task automatic test_random();
    int ec; bit et;
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < NP; i++) begin
        p_stale[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 1)) : -1;
        p_delay[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 3));
      end
      run_seq("random");
      checks++;
      if (rq.size() != NP) begin
        failures++;
        $display("FAIL random%0d_count: results=%0d, required %0d", s, rq.size(), NP);
      end
      for (int i = 0; i < NP && i < rq.size(); i++) begin
        model(p_delay[i], p_stale[i], ec, et);
        checks += 2;
        if (rq[i].cyc != ec || rq[i].idx != i) begin
          failures++;
          $display("FAIL random%0d_cycles%0d: got idx=%0d cyc=%0d, required idx=%0d cyc=%0d (d=%0d s=%0d)",
                   s, i, rq[i].idx, rq[i].cyc, i, ec, p_delay[i], p_stale[i]);
        end
        if (rq[i].to != et) begin
          failures++;
          $display("FAIL random%0d_timeout%0d: got %0b, required %0b", s, i, rq[i].to, et);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin p_delay[i] = -1; p_stale[i] = -1; end
    rst_cnt = 0;
    test_reset();
    test_normal();
    test_corners();
    test_relaunch();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_launcher.md
Name: prog_launcher

Overview:
- Synthesizable initiator for the core's start/done program-sequencing handshake; replaces the bench-side stimulus for FPGA self-test.
- Resets the core once, then issues a start pulse for each of NUM_PROGS programs in turn.
- After each start it waits for the core's done, measures the run length in cycles, and reports one result per program.
- Sits between the board-level go button or host and the processor top, and drives the core's reset and start inputs.

Parameters:
- NUM_PROGS, 3: number of programs launched per sequence (1..15).
- START_CYCLES, 2: cycles start is held high per launch (>=1).
- CW, 16: width of the cycle counter and result.
- TIMEOUT, 16'hFFF0: cycle count at which a run is abandoned (< 2^CW - 1).

Ports:
- clk, input, 1: clock; all state changes on posedge.
- reset, input, 1: synchronous, active-high reset.
- go, input, 1: begin a sequence; level, sampled only in IDLE or FINISHED.
- done_in, input, 1: core done/halt flag, level.
- core_reset, output, 1: reset to the core.
- start, output, 1: start request to the core.
- prog_idx, output, 4: index of the current program (0..NUM_PROGS-1).
- busy, output, 1: high in every state except IDLE and FINISHED.
- result_valid, output, 1: one-cycle pulse when a result is recorded.
- result_cycles, output, CW: run length of the program just completed.
- result_timeout, output, 1: qualifies result_valid; high means the run hit TIMEOUT.
- all_done, output, 1: high in FINISHED.

Behaviour:
- Reset values:
  - state is IDLE.
  - core_reset is 1. It is held while the launcher is reset, then drops to 0 on leaving reset.
  - start=0, prog_idx=0, busy=0, result_valid=0, result_cycles=0, result_timeout=0, all_done=0.
  - Internal cycle counter=0, hold counter=0, done_armed=0.
- All outputs are registered, so each output changes on the clock edge where its state is entered.
- States and transitions:
  - IDLE: when go=1, go to CORE_RST.
  - CORE_RST: core_reset=1 for exactly 1 cycle; prog_idx<=0; then START_HI.
  - START_HI: start=1 for START_CYCLES cycles, counted by the hold counter. done_armed<=1 on any cycle with done_in=0. Then RUN.
  - RUN: start=0. The counter resets to 0 on entry and increments by 1 each cycle in RUN.
    - If done_in=0 in a cycle, set done_armed<=1.
    - If done_armed=1 and done_in=1, go to RECORD.
    - If counter==TIMEOUT, go to RECORD with the timeout flag set.
    - Done takes priority over timeout when both occur in the same cycle.
  - RECORD (1 cycle):
    - result_valid=1, result_cycles<=counter, result_timeout<=flag; done_armed<=0.
    - If prog_idx==NUM_PROGS-1, go to FINISHED.
    - Otherwise prog_idx<=prog_idx+1 and go to START_HI.
  - FINISHED: all_done=1; prog_idx holds NUM_PROGS-1. When go=1, go to CORE_RST, which starts a new sequence with prog_idx back to 0.
- Stale-done rule: a done_in still high from the previous program never completes the next run. done_armed must first observe done_in=0 at least once after the start assertion.
- Core reset is issued only at the start of a sequence, never between programs. The core keeps its state across programs.
- Counter arithmetic: unsigned CW bits; it cannot wrap because TIMEOUT < 2^CW - 1.
- result_cycles and result_timeout hold their values until the next RECORD.
- go: held high is treated as a single request per sequence. FINISHED re-launches on go=1 in the same cycle, so a held go re-runs continuously; this is by design.
- Reset mid-operation: any state returns to IDLE on the next edge with the reset values above; a pending result is discarded.
- Ignored inputs: done_in in IDLE, CORE_RST and FINISHED; go outside IDLE and FINISHED.

Decomposition:
- Package prog_launcher_pkg holds:
  - state_t enum {IDLE, CORE_RST, START_HI, RUN, RECORD, FINISHED};
  - the prog_idx width constant PIW=4.
- Sub-module run_timer: a CW-bit counter with clear, enable and compare-to-TIMEOUT. It is instantiated once and owns the counter and the timeout-hit output.
- The FSM stays in prog_launcher.

Test Plan:
- Normal run:
  - Setup: NUM_PROGS=3, START_CYCLES=2; go pulsed; a core model raises done_in 10, 25 and 7 cycles after each start falls.
  - Expect: 3 result_valid pulses, result_cycles=10, 25, 7, result_timeout=0, prog_idx=0, 1, 2.
  - Expect: all_done=1 after the third result; core_reset high exactly 1 cycle after go.
- Stale done:
  - Setup: done_in stays 1 through START_HI and the first 4 RUN cycles, goes 0 for 1 cycle, then 1 again.
  - Expect: a single result with result_cycles=5.
- Timeout:
  - Setup: TIMEOUT=20; done_in held 0.
  - Expect: a result after 21 RUN cycles with result_cycles=20, result_timeout=1; the sequence advances to the next prog_idx.
- Simultaneous done and timeout:
  - Setup: done_in rises on the cycle where counter==TIMEOUT.
  - Expect: result_timeout=0, result_cycles=TIMEOUT.
- Mid-run reset:
  - Setup: assert reset during RUN of program 1.
  - Expect next edge: state IDLE, prog_idx=0, start=0, busy=0, core_reset=1, no result_valid.
  - Expect after reset drops: core_reset=0; go restarts from program 0.
- Re-launch:
  - Setup: pulse go while in FINISHED.
  - Expect: CORE_RST 1 cycle, prog_idx=0, all_done falls to 0 on the same edge, start high exactly 2 cycles.
